// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS pin-bus arbiter: FSM states, grant
// owners and the byte-beat geometry of one 32-bit word.
package mips_bus_pkg;

   typedef enum logic [1:0] {IDLE, XFER, ACK} state_e;
   typedef enum logic {FETCH, DATA} grant_e;

   localparam int BEATS  = 4;
   localparam int BEAT_W = 2;

   // Little-endian byte lane of a word: beat 0 is bits [7:0].
   function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                           input logic [BEAT_W-1:0] beat);
      return word[{beat, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mips_bus_beat_timer.sv
// Beat sequencer for one word transfer: wcnt paces each byte beat over
// BEAT_CYC cycles, beat walks the four byte lanes.
module mips_bus_beat_timer
   import mips_bus_pkg::*;
#(
   parameter int BEAT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              enable_i,
   output logic [BEAT_W-1:0] beat_o,
   output logic              beat_last_cyc_o,
   output logic              word_done_o
);

   localparam int WCNT_W = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(BEAT_CYC - 1);
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BEATS - 1);

   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   always_comb begin
      beat_last_cyc_o = enable_i && (wcnt_q == WCNT_MAX);
      word_done_o     = beat_last_cyc_o && (beat_q == BEAT_MAX);
      wcnt_d          = wcnt_q;
      beat_d          = beat_q;
      if (clear_i) begin
         wcnt_d = '0;
         beat_d = '0;
      end else if (enable_i) begin
         if (beat_last_cyc_o) begin
            wcnt_d = '0;
            beat_d = beat_q + 1'b1;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q <= '0;
         beat_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         beat_q <= beat_d;
      end
   end

   assign beat_o = beat_q;

endmodule

// File: rtl/mips_pin_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit pin bus between instruction fetch and
// data ports; each word moves as four little-endian byte beats.
module mips_pin_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int BEAT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_ack,
   output logic [31:0]       dm_rdata,
   output logic [ADDR_W-1:0] ext_addr,
   output logic [7:0]        ext_wdata,
   input  logic [7:0]        ext_rdata,
   output logic              ext_we,
   output logic              ext_strobe,
   output logic              busy
);

   state_e               state_q, state_d;
   grant_e               last_grant_q, last_grant_d;
   grant_e               gnt;
   logic [ADDR_W-3:0]    word_q, word_d;
   logic                 we_q, we_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rbuf_q, rbuf_d;
   logic [31:0]          if_rdata_q, if_rdata_d;
   logic [31:0]          dm_rdata_q, dm_rdata_d;
   logic [BEAT_W-1:0]    beat;
   logic                 beat_last_cyc;
   logic                 word_done;

   mips_bus_beat_timer #(.BEAT_CYC(BEAT_CYC)) u_timer (
      .clk             (clk),
      .rst             (rst),
      .clear_i         (state_q != XFER),
      .enable_i        (state_q == XFER),
      .beat_o          (beat),
      .beat_last_cyc_o (beat_last_cyc),
      .word_done_o     (word_done)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt          = last_grant_q;
      word_d       = word_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      rbuf_d       = rbuf_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      ext_addr     = '0;
      ext_wdata    = '0;
      ext_we       = 1'b0;
      ext_strobe   = 1'b0;
      if_ack       = 1'b0;
      dm_ack       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               if (if_req && dm_req)
                  gnt = (last_grant_q == FETCH) ? DATA : FETCH;
               else
                  gnt = dm_req ? DATA : FETCH;
               last_grant_d = gnt;
               state_d      = XFER;
               if (gnt == DATA) begin
                  word_d  = dm_addr[ADDR_W-1:2];
                  we_d    = dm_we;
                  wdata_d = dm_wdata;
               end else begin
                  word_d  = if_addr[ADDR_W-1:2];
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
            end
         end
         XFER: begin
            ext_strobe = 1'b1;
            ext_addr   = {word_q, beat};
            ext_we     = we_q;
            ext_wdata  = byte_sel(wdata_q, beat);
            if (beat_last_cyc && !we_q)
               rbuf_d[{beat, 3'b000} +: 8] = ext_rdata;
            // Publish the word as it completes so rdata only changes at acks.
            if (word_done) begin
               state_d = ACK;
               if (!we_q) begin
                  if (last_grant_q == DATA)
                     dm_rdata_d = {ext_rdata, rbuf_q[23:0]};
                  else
                     if_rdata_d = {ext_rdata, rbuf_q[23:0]};
               end
            end
         end
         ACK: begin
            if_ack  = (last_grant_q == FETCH);
            dm_ack  = (last_grant_q == DATA);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= FETCH;
         word_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         rbuf_q       <= '0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         word_q       <= word_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         rbuf_q       <= rbuf_d;
         if_rdata_q   <= if_rdata_d;
         dm_rdata_q   <= dm_rdata_d;
      end
   end

   assign if_rdata = if_rdata_q;
   assign dm_rdata = dm_rdata_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mips_pin_bus_arbiter.sv
// Bench for mips_pin_bus_arbiter: transaction-level model plus directed
// scenarios on a BEAT_CYC=2 instance and a BEAT_CYC=1 instance.
module tb_mips_pin_bus_arbiter;

   localparam int BC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        if_req, dm_req, dm_we;
   logic [7:0]  if_addr, dm_addr;
   logic [31:0] dm_wdata;
   logic        if_ack, dm_ack, ext_we, ext_strobe, busy;
   logic [31:0] if_rdata, dm_rdata;
   logic [7:0]  ext_addr, ext_wdata, ext_rdata;

   logic        b_if_req;
   logic [7:0]  b_if_addr;
   logic        b_if_ack, b_dm_ack, b_ext_we, b_ext_strobe, b_busy;
   logic [31:0] b_if_rdata, b_dm_rdata;
   logic [7:0]  b_ext_addr, b_ext_wdata, b_ext_rdata;

   assign ext_rdata   = ext_addr ^ 8'hA5;
   assign b_ext_rdata = b_ext_addr ^ 8'hA5;

   mips_pin_bus_arbiter #(.ADDR_W(8), .BEAT_CYC(BC)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
      .ext_we(ext_we), .ext_strobe(ext_strobe), .busy(busy)
   );

   mips_pin_bus_arbiter #(.ADDR_W(8), .BEAT_CYC(1)) dut_b (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(8'h00), .dm_wdata(32'h0),
      .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
      .ext_addr(b_ext_addr), .ext_wdata(b_ext_wdata), .ext_rdata(b_ext_rdata),
      .ext_we(b_ext_we), .ext_strobe(b_ext_strobe), .busy(b_busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [5:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] b;
         b = i[1:0];
         r[8*i +: 8] = {w, b} ^ 8'hA5;
      end
      return r;
   endfunction

   // Transaction model: a granted word occupies cycles k=0..4*BC-1 with the
   // strobe, then one ack cycle at k=4*BC, then the bus is free again.
   bit          m_active = 1'b0;
   int          m_k = 0;
   bit          m_port = 1'b0;     // 0 fetch, 1 data
   bit          m_last = 1'b0;
   logic [5:0]  m_word = '0;
   bit          m_we = 1'b0;
   logic [31:0] m_wdata = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 1'b0;
         m_last   = 1'b0;
         m_k      = 0;
      end else if (!m_active) begin
         if (if_req || dm_req) begin
            m_port   = (if_req && dm_req) ? !m_last : dm_req;
            m_last   = m_port;
            m_active = 1'b1;
            m_k      = 0;
            if (m_port) begin
               m_word = dm_addr[7:2]; m_we = dm_we; m_wdata = dm_wdata;
            end else begin
               m_word = if_addr[7:2]; m_we = 1'b0; m_wdata = '0;
            end
         end
      end else if (m_k == 4*BC) begin
         m_active = 1'b0;
      end else begin
         m_k++;
      end
   end

   bit e_strobe, e_ack;
   int beat_i;
   logic [1:0] beat2;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_strobe", ext_strobe, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_acks", {if_ack, dm_ack}, 2'b00);
      end else begin
         e_strobe = m_active && (m_k < 4*BC);
         e_ack    = m_active && (m_k == 4*BC);
         chk("strobe", ext_strobe, e_strobe);
         chk("busy", busy, m_active);
         chk("if_ack", if_ack, e_ack && !m_port);
         chk("dm_ack", dm_ack, e_ack && m_port);
         chk("ext_we", ext_we, e_strobe && m_we);
         if (e_strobe) begin
            beat_i = m_k / BC;
            beat2  = beat_i[1:0];
            chk("ext_addr", ext_addr, {m_word, beat2});
            chk("ext_wdata", ext_wdata, m_wdata[8*beat_i +: 8]);
         end
         if (e_ack && !m_we) begin
            if (m_port) chk("dm_rdata", dm_rdata, exp_word(m_word));
            else        chk("if_rdata", if_rdata, exp_word(m_word));
         end
      end
   end

   logic [7:0] addr_log[$];
   logic [7:0] wd_log[$];
   bit         we_all;
   bit         saw_if;

   // Counts negedges since the request was driven; returns the ack cycle.
   task automatic wait_ack(input int sel, output int cyc);
      cyc = -1;
      addr_log.delete(); wd_log.delete();
      we_all = 1'b1; saw_if = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (sel == 2) begin
            if (b_ext_strobe) addr_log.push_back(b_ext_addr);
         end else if (ext_strobe) begin
            addr_log.push_back(ext_addr);
            wd_log.push_back(ext_wdata);
            we_all = we_all & ext_we;
         end
         if (if_ack) saw_if = 1'b1;
         if ((sel == 0 && if_ack) || (sel == 1 && dm_ack) || (sel == 2 && b_if_ack)) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) begin
         checks++; errors++;
         $display("FAIL ack_timeout sel=%0d actual=none required=ack", sel);
      end
   endtask

   int c;
   int ack_cyc[$];
   int ack_port[$];

   initial begin
      rst = 1'b1;
      if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
      b_if_req = 0; b_if_addr = 0;
      repeat (3) @(negedge clk);
      chk("reset_if_rdata", if_rdata, 32'h0);
      chk("reset_dm_rdata", dm_rdata, 32'h0);
      chk("reset_ext_we", ext_we, 1'b0);
      rst = 1'b0;

      // Fetch only
      @(negedge clk);
      if_req = 1; if_addr = 8'h10;
      wait_ack(0, c);
      if_req = 0;
      chk("t1_ack_cycle", c, 9);
      chk("t1_beats", addr_log.size(), 8);
      for (int i = 0; i < 8 && i < addr_log.size(); i++)
         chk("t1_ext_addr", addr_log[i], 8'h10 + 8'(i/2));
      chk("t1_rdata", if_rdata, 32'hB6B7B4B5);

      // Store
      @(negedge clk);
      dm_req = 1; dm_we = 1; dm_addr = 8'h23; dm_wdata = 32'hDEADBEEF;
      wait_ack(1, c);
      dm_req = 0;
      chk("t2_ack_cycle", c, 9);
      chk("t2_we", we_all, 1'b1);
      chk("t2_no_if_ack", saw_if, 1'b0);
      if (addr_log.size() == 8) begin
         chk("t2_addr0", addr_log[0], 8'h20);
         chk("t2_addr7", addr_log[7], 8'h23);
         chk("t2_wd0", wd_log[0], 8'hEF);
         chk("t2_wd2", wd_log[2], 8'hBE);
         chk("t2_wd4", wd_log[4], 8'hAD);
         chk("t2_wd6", wd_log[6], 8'hDE);
      end else chk("t2_beats", addr_log.size(), 8);

      // Contention from reset, requests held high
      @(negedge clk);
      rst = 1; if_req = 1; dm_req = 1; dm_we = 0; if_addr = 8'h04; dm_addr = 8'h08;
      @(negedge clk);
      rst = 0;
      ack_cyc.delete(); ack_port.delete();
      for (int i = 1; i <= 60 && ack_cyc.size() < 3; i++) begin
         @(negedge clk);
         if (if_ack || dm_ack) begin
            ack_cyc.push_back(i);
            ack_port.push_back(int'(dm_ack));
         end
      end
      if_req = 0; dm_req = 0;
      chk("t3_acks", ack_cyc.size(), 3);
      if (ack_cyc.size() == 3) begin
         chk("t3_g0_data", ack_port[0], 1);
         chk("t3_g1_fetch", ack_port[1], 0);
         chk("t3_g2_data", ack_port[2], 1);
         chk("t3_cyc0", ack_cyc[0], 9);
         chk("t3_cyc1", ack_cyc[1], 19);
         chk("t3_cyc2", ack_cyc[2], 29);
      end

      // Request dropped during beat 1
      @(negedge clk);
      dm_req = 1; dm_we = 0; dm_addr = 8'h47;
      c = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 3) begin dm_req = 0; dm_addr = 8'h99; end
         if (dm_ack) begin c = i; break; end
      end
      chk("t4_ack_cycle", c, 9);
      chk("t4_rdata", dm_rdata, 32'hE2E3E0E1);

      // Reset during beat 2
      @(negedge clk);
      if_req = 1; if_addr = 8'h30;
      repeat (5) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("t5_strobe_async", ext_strobe, 1'b0);
      chk("t5_busy_async", busy, 1'b0);
      if_req = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      if_req = 1; if_addr = 8'h31;
      wait_ack(0, c);
      if_req = 0;
      chk("t5_ack_cycle", c, 9);
      chk("t5_rdata", if_rdata, 32'h96979495);

      // Single-cycle beats
      @(negedge clk);
      b_if_req = 1; b_if_addr = 8'hFC;
      wait_ack(2, c);
      b_if_req = 0;
      chk("t6_ack_cycle", c, 5);
      chk("t6_beats", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         chk("t6_ext_addr", addr_log[i], 8'hFC + 8'(i));
      chk("t6_rdata", b_if_rdata, 32'h5A5B5859);

      // Random traffic checked by the model every cycle
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if_req   = ($urandom_range(0, 3) != 0);
         dm_req   = ($urandom_range(0, 2) != 0);
         dm_we    = $urandom_range(0, 1) != 0;
         if_addr  = 8'($urandom);
         dm_addr  = 8'($urandom);
         dm_wdata = $urandom;
      end
      if_req = 0; dm_req = 0;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
